// File: rtl/iter_alu_if.sv
// Request/response bundle between EX-stage control and the iterative ALU.
// Control drives the request side; the ALU returns results and HI/LO.
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  result, zero, busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output result, zero, busy, done, div0, hi, lo
    );
endinterface

// File: rtl/iter_alu.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative
// MIPS multiply/divide with HI/LO registers.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    iter_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_hi, p_lo, dsr;
    logic             sa, sb, md;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, done_q, div0_q;

    logic             busy, accept;
    logic             is_mul, is_div, is_sgn, dz;
    logic             na, nb;
    logic [WIDTH-1:0] ma, mb;
    logic [WIDTH-1:0] alu_res;

    assign is_mul = (bus.op == 4'b1000) || (bus.op == 4'b1001);
    assign is_div = (bus.op == 4'b1010) || (bus.op == 4'b1011);
    assign is_sgn = (bus.op == 4'b1000) || (bus.op == 4'b1010);
    assign dz     = is_div && (bus.b == '0);

    assign busy   = (state == MUL) || (state == DIV) || (state == FIX);
    assign accept = bus.start && !busy;

    // Divide-by-zero runs unsigned so the engine naturally yields ~0 and raw a
    assign na = is_sgn && bus.a[WIDTH-1] && !dz;
    assign nb = is_sgn && bus.b[WIDTH-1];
    assign ma = na ? -bus.a : bus.a;
    assign mb = nb ? -bus.b : bus.b;

    always_comb begin
        alu_res = '0;
        case (bus.op)
            4'b0000: alu_res = bus.a & bus.b;
            4'b0001: alu_res = bus.a | bus.b;
            4'b0010: alu_res = bus.a + bus.b;
            4'b0110: alu_res = bus.a - bus.b;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}},
                                ($signed(bus.a) < $signed(bus.b))};
            4'b0011: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            4'b1100: alu_res = hi_q;
            4'b1101: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem;

    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, dsr} : '0);
    assign div_sh  = {p_hi, p_lo[WIDTH-1]};
    assign div_ok  = div_sh >= {1'b0, dsr};
    // A successful trial difference is below dsr, so W bits hold it exactly
    assign div_rem = div_ok ? (div_sh[WIDTH-1:0] - dsr) : div_sh[WIDTH-1:0];

    logic [2*WIDTH-1:0] prod, fprod;
    logic [WIDTH-1:0]   f_hi, f_lo;

    always_comb begin
        prod  = {p_hi, p_lo};
        fprod = (sa ^ sb) ? -prod : prod;
        if (md) begin
            f_lo = (sa ^ sb) ? -p_lo : p_lo;
            f_hi = sa ? -p_hi : p_hi;
        end else begin
            f_lo = fprod[WIDTH-1:0];
            f_hi = fprod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (accept && is_mul)      state_nx = MUL;
                else if (accept && is_div) state_nx = DIV;
            end
            MUL, DIV: if (cnt == LAST) state_nx = FIX;
            FIX:      state_nx = DONE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            dsr      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            md       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                div0_q <= dz;
                cnt    <= '0;
                if (is_mul || is_div) begin
                    sa   <= na;
                    sb   <= nb;
                    md   <= is_div;
                    p_hi <= '0;
                    p_lo <= is_div ? ma : mb;
                    dsr  <= is_div ? mb : ma;
                end else begin
                    result_q <= alu_res;
                    zero_q   <= (alu_res == '0);
                    done_q   <= 1'b1;
                end
            end
            case (state)
                MUL: begin
                    {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    p_hi <= div_rem;
                    p_lo <= {p_lo[WIDTH-2:0], div_ok};
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    hi_q     <= f_hi;
                    lo_q     <= f_lo;
                    result_q <= f_lo;
                    zero_q   <= (f_lo == '0);
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.div0   = div0_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule
